// File: rtl/sim_ioctl_pkg.sv
// Shared state encoding and default pacing for the simulation ioctl download sender.
package sim_ioctl_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned DEF_LEAD   = 4;
    localparam int unsigned DEF_WR_GAP = 8;
    localparam int unsigned DEF_TAIL   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Load value that makes the pace counter reach zero after n cycles in a state
    function automatic logic [CNT_W-1:0] pace_load(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/sim_ioctl_pace_cnt.sv
// Loadable down-counter with zero flag; times the LEAD, GAP and TAIL phases.
module sim_ioctl_pace_cnt
    import sim_ioctl_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/sim_ioctl_sender.sv
// Harness-side ioctl download transmitter: paces a valid/ready byte stream into
// ioctl_wr strobes with incrementing address, framed by ioctl_download.
module sim_ioctl_sender
    import sim_ioctl_pkg::*;
#(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned LEAD   = DEF_LEAD,
    parameter int unsigned WR_GAP = DEF_WR_GAP,
    parameter int unsigned TAIL   = DEF_TAIL
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rem;
    logic [ADDR_W-1:0] r_ioctl_addr;
    logic [7:0]        r_dout;
    logic [7:0]        r_index;
    logic              r_in_ready;
    logic              r_download;
    logic              r_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              r_abort_seen;

    logic              w_zero;
    logic              w_strobe;
    logic              w_accept;
    logic              w_abort;
    logic              w_to_tail;
    logic              w_to_gap;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_dec;

    sim_ioctl_pace_cnt u_pace (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero_c   (w_zero)
    );

    // Transition qualifiers and pace counter control
    always_comb begin
        w_strobe   = (r_state == ST_WRITE) && !ioctl_wait;
        w_accept   = (r_state == ST_FETCH) && in_valid && r_in_ready;
        w_abort    = abort && ((r_state == ST_LEAD) || (r_state == ST_FETCH) ||
                               (r_state == ST_WRITE) || (r_state == ST_GAP));
        w_to_tail  = w_abort ||
                     ((r_state == ST_LEAD) && w_zero && (r_rem == '0)) ||
                     (w_strobe && (r_rem <= ADDR_W'(1)));
        w_to_gap   = w_strobe && !w_to_tail && (WR_GAP != 0);
        w_load     = 1'b0;
        w_load_val = '0;
        if ((r_state == ST_IDLE) && start) begin
            w_load     = 1'b1;
            w_load_val = pace_load(LEAD);
        end else if (w_to_tail) begin
            w_load     = 1'b1;
            w_load_val = pace_load(TAIL);
        end else if (w_to_gap) begin
            w_load     = 1'b1;
            w_load_val = pace_load(WR_GAP);
        end
        w_dec = ((r_state == ST_LEAD) || (r_state == ST_GAP) || (r_state == ST_TAIL)) && !w_zero;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rem        <= '0;
            r_ioctl_addr <= '0;
            r_dout       <= '0;
            r_index      <= '0;
            r_in_ready   <= 1'b0;
            r_download   <= 1'b0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_seen <= 1'b0;
        end else begin
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b0;
            if (w_abort) begin
                r_abort_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_LEAD;
                        r_index      <= index;
                        r_rem        <= len;
                        r_addr       <= '0;
                        r_abort_seen <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_download   <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_LEAD: begin
                    if (w_to_tail) begin
                        r_state <= ST_TAIL;
                    end else if (w_zero) begin
                        r_state    <= ST_FETCH;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // An abort wins over a same-cycle accept, so that byte is dropped
                    if (w_to_tail) begin
                        r_state <= ST_TAIL;
                    end else if (w_accept) begin
                        r_dout  <= in_data;
                        r_state <= ST_WRITE;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_strobe) begin
                        r_wr         <= 1'b1;
                        r_ioctl_addr <= r_addr;
                        r_addr       <= r_addr + ADDR_W'(1);
                        if (r_rem != '0) begin
                            r_rem <= r_rem - ADDR_W'(1);
                        end
                    end
                    if (w_to_tail) begin
                        r_state <= ST_TAIL;
                    end else if (w_to_gap) begin
                        r_state <= ST_GAP;
                    end else if (w_strobe) begin
                        r_state    <= ST_FETCH;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_to_tail) begin
                        r_state <= ST_TAIL;
                    end else if (w_zero) begin
                        r_state    <= ST_FETCH;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (w_zero) begin
                        r_state    <= ST_DONE;
                        r_download <= 1'b0;
                        r_done     <= 1'b1;
                        r_aborted  <= r_abort_seen;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign ioctl_download = r_download;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_ioctl_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign busy           = r_busy;
    assign done           = r_done;
    assign aborted        = r_aborted;

endmodule
